// File: rtl/s2p_rx_ctrl.sv
// s2p_rx_ctrl: receive sequencer that drives the chat-link S2P shift register and holds each received byte.
// Define RX_PARITY_EN to add an even-parity bit between the data and stop bits (adds parityErr).
module s2p_rx_ctrl #(
  parameter int OVERSAMPLE = 16,
  parameter int CNT_W      = 5
) (
  input  logic       srClock,
  input  logic       rst,
  input  logic       serialIn,
  output logic       shiftEn,
  output logic       shiftBit,
  input  logic [7:0] s2pData,
  output logic [7:0] rxData,
  output logic       rxValid,
  input  logic       rxReady,
  input  logic       clrErr,
  output logic       frameErr,
  output logic       overrun,
  output logic       busy
`ifdef RX_PARITY_EN
  ,
  output logic       parityErr
`endif
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] STOP      = 3'd3;
  localparam logic [2:0] WAIT_HIGH = 3'd4;
`ifdef RX_PARITY_EN
  localparam logic [2:0] PARITY    = 3'd5;
`endif

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(OVERSAMPLE - 1);

  logic             syncMeta;
  logic             syncIn;
  logic             syncPrev;
  logic [2:0]       state;
  logic [2:0]       stateNext;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cntNext;
  logic [2:0]       bitCnt;

  logic startEdge;
  logic halfDone;
  logic fullDone;
  logic startSample;
  logic dataSample;
  logic stopSample;
  logic goodStop;
  logic badStop;
  logic consume;
  logic dropByte;
  logic capture;

  // Idle-high synchronizer so reset never looks like a start edge.
  always_ff @(posedge srClock or negedge rst) begin
    if (!rst) begin
      syncMeta <= 1'b1;
      syncIn   <= 1'b1;
      syncPrev <= 1'b1;
    end else begin
      syncMeta <= serialIn;
      syncIn   <= syncMeta;
      syncPrev <= syncIn;
    end
  end

  assign startEdge   = syncPrev & ~syncIn;
  assign halfDone    = (cnt == HALF_CNT);
  assign fullDone    = (cnt == FULL_CNT);
  assign startSample = (state == START) & halfDone;
  assign dataSample  = (state == DATA) & fullDone;
  assign stopSample  = (state == STOP) & fullDone;
  assign goodStop    = stopSample & syncIn;
  assign badStop     = stopSample & ~syncIn;
  assign consume     = rxValid & rxReady;
  assign dropByte    = goodStop & rxValid & ~rxReady;
  assign capture     = goodStop & ~dropByte;

  // Strobe is combinational so the S2P shifts on the same edge the bit is sampled.
  assign shiftEn  = dataSample;
  assign shiftBit = dataSample & syncIn;
  assign busy     = (state != IDLE);

  always_comb begin
    stateNext = state;
    cntNext   = cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        cntNext = '0;
        if (startEdge) stateNext = START;
      end
      START: begin
        if (halfDone) begin
          cntNext   = '0;
          stateNext = syncIn ? IDLE : DATA;
        end
      end
      DATA: begin
        if (fullDone) begin
          cntNext = '0;
          if (bitCnt == 3'd7) begin
`ifdef RX_PARITY_EN
            stateNext = PARITY;
`else
            stateNext = STOP;
`endif
          end
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (fullDone) begin
          cntNext   = '0;
          stateNext = STOP;
        end
      end
`endif
      STOP: begin
        if (fullDone) begin
          cntNext   = '0;
          stateNext = syncIn ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        cntNext = '0;
        if (syncIn) stateNext = IDLE;
      end
      default: begin
        cntNext   = '0;
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge srClock or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_ff @(posedge srClock or negedge rst) begin
    if (!rst) begin
      bitCnt <= 3'd0;
    end else if (startSample) begin
      bitCnt <= 3'd0;
    end else if (dataSample) begin
      bitCnt <= bitCnt + 3'd1;
    end
  end

  // A capture in the same cycle as a consume keeps rxValid high with the new byte.
  always_ff @(posedge srClock or negedge rst) begin
    if (!rst) begin
      rxData  <= 8'h00;
      rxValid <= 1'b0;
    end else if (capture) begin
      rxData  <= s2pData;
      rxValid <= 1'b1;
    end else if (consume) begin
      rxValid <= 1'b0;
    end
  end

  always_ff @(posedge srClock or negedge rst) begin
    if (!rst) begin
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (badStop) frameErr <= 1'b1;
      else if (clrErr) frameErr <= 1'b0;
      if (dropByte) overrun <= 1'b1;
      else if (clrErr) overrun <= 1'b0;
    end
  end

`ifdef RX_PARITY_EN
  logic paritySample;
  logic parityAcc;
  logic parityBad;

  assign paritySample = (state == PARITY) & fullDone;

  // Running XOR of the data bits; parityBad is held until the stop bit decides the frame.
  always_ff @(posedge srClock or negedge rst) begin
    if (!rst) begin
      parityAcc <= 1'b0;
      parityBad <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      if (startSample) begin
        parityAcc <= 1'b0;
        parityBad <= 1'b0;
      end else if (dataSample) begin
        parityAcc <= parityAcc ^ syncIn;
      end else if (paritySample) begin
        parityBad <= (syncIn != parityAcc);
      end
      if (goodStop & parityBad) parityErr <= 1'b1;
      else if (clrErr) parityErr <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/s2p_rx_ctrl.md
# s2p_rx_ctrl

Receive-side sequencer for the serial-to-parallel shift register (S2P) in the chat link datapath. Detects and validates each asynchronous serial frame: start bit, 8 data bits LSB-first, stop bit. Strobes the S2P once per data bit at mid-bit, latches the assembled byte into a holding register and offers it to the chat logic over a valid/ready handshake. Sits between the board serial input pin and the character buffer; the S2P is its only datapath.

## Interface
Parameters:
- OVERSAMPLE, 16, srClock cycles per serial bit; even, ≥4
- CNT_W, 5, width of the oversample counter; must hold OVERSAMPLE-1

Ports:
- srClock  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- serialIn  in  1  raw serial line, idle high, asynchronous to srClock
- shiftEn  out  1  one-cycle strobe to S2P: shift in shiftBit
- shiftBit  out  1  sampled data bit presented with shiftEn
- s2pData  in  8  S2P parallel output; first-received bit in bit 0 after eight shifts
- rxData  out  8  holding register, valid while rxValid=1
- rxValid  out  1  byte available
- rxReady  in  1  consumer accepts the byte when rxValid&rxReady
- clrErr  in  1  synchronous clear of sticky error flags
- frameErr  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: good frame arrived while holding register still full
- busy  out  1  high in every state except IDLE

## Operation
- serialIn passes through a 2-flop synchronizer (reset to 1); all decisions use the synchronized value syncIn.
- States: IDLE, START, DATA, STOP, WAIT_HIGH; PARITY only with the macro.
- IDLE: a syncIn 1→0 edge loads the counter and moves to START.
- START: after OVERSAMPLE/2 cycles, sample syncIn. Low → DATA, bitCnt=0. High → false start, return to IDLE with no strobe and no flag.
- DATA: every OVERSAMPLE cycles, sample syncIn. Drive shiftBit=sample, pulse shiftEn for one cycle, increment bitCnt. After bit 7 go to STOP.
- STOP: sample after OVERSAMPLE cycles.
  - High: if rxValid=1 and rxReady=0 that cycle, set overrun and drop the byte. Otherwise rxData←s2pData and rxValid←1. Return to IDLE.
  - Low: set frameErr, no capture, go to WAIT_HIGH.
- WAIT_HIGH: stay until syncIn=1, then IDLE. This prevents a break condition from retriggering as a start edge.
- rxValid clears on the cycle after rxValid&rxReady. Simultaneous consume and capture: new byte loads, rxValid stays 1, no overrun.
- clrErr clears frameErr, overrun and parityErr. A set event in the same cycle wins over clrErr.
- Reset mid-frame: immediate return to IDLE; the partial byte is abandoned and nothing is flagged.

## Timing
- Reset values: shiftEn=0, shiftBit=0, rxData=8'h00, rxValid=0, frameErr=0, overrun=0, busy=0, state IDLE, counters 0.
- t = first cycle syncIn is low; this is 2–3 cycles after the pin falls.
- Start sample at t+OVERSAMPLE/2.
- Data bit i (0..7) sampled, with shiftEn high, at t+OVERSAMPLE/2+(i+1)·OVERSAMPLE.
- Stop sample at t+OVERSAMPLE/2+9·OVERSAMPLE; rxValid rises the following cycle. S2P output is settled because the last shift precedes the stop sample by OVERSAMPLE cycles.
- Back-to-back frames: a new start edge is accepted the first IDLE cycle after the stop sample.

## Configuration
- RX_PARITY_EN defined: a PARITY state sits between DATA and STOP. It samples one even-parity bit, which is not shifted into the S2P. Stop sample moves to t+OVERSAMPLE/2+10·OVERSAMPLE. Adds output parityErr (1 bit, sticky, reset 0). A parity mismatch on a frame with a good stop bit sets parityErr and still captures the byte.
- Undefined: no PARITY state and no parityErr port; frame is 10 bits.

## Test plan
Bench uses OVERSAMPLE=4 and a behavioural S2P honouring shiftEn.
- Reset, then frame 0x5A with rxReady=0 → exactly 8 shiftEn pulses, bits 0,1,0,1,1,0,1,0. rxData=8'h5A and rxValid=1 at t+39; busy low afterwards.
- Line low for 1 cycle only (glitch) → back to IDLE from START. No shiftEn, no flags.
- Frame 0x3C with stop bit low, line held low 20 cycles → frameErr=1, rxValid=0. No new frame starts until the line returns high; clrErr then clears frameErr.
- Frames 0x11 then 0x22 back-to-back, rxReady=0 → rxData stays 8'h11, overrun=1. Repeat with rxReady pulsed in the 0x22 capture cycle → rxData=8'h22, overrun=0.
- Assert rst low during data bit 4 of 0xFF, then send 0x81 → all outputs at reset values during reset; next byte is 8'h81.
- With RX_PARITY_EN: send 0x07 with parity bit 0 → rxData=8'h07, parityErr=1. Send 0x07 with parity bit 1 → parityErr unchanged.
